// File: rtl/hack_pkg.sv
// Shared types and sizes for the HACK boot-loader slice.
package hack_pkg;

    localparam int HACK_ADDR_W = 15;
    localparam int HACK_DATA_W = 16;
    localparam int ROM_DEPTH   = 1 << HACK_ADDR_W;

    // Boot-loader sequencing states: length word, data words, checksum word, then a terminal state.
    typedef enum logic [2:0] {
        LEN   = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } loaderState_t;

endpackage

// File: rtl/hack_boot_loader.sv
// Loads a length-framed, checksummed image from a 16-bit word stream into the
// HACK instruction ROM, holding the CPU in reset until the image verifies.
module hack_boot_loader
    import hack_pkg::*;
#(
    parameter int ADDR_W = HACK_ADDR_W,
    parameter int DATA_W = HACK_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    loaderState_t      stateReg;
    loaderState_t      stateNext;

    logic [ADDR_W:0]   lenReg;
    logic [DATA_W-1:0] sumReg;
    logic [ADDR_W-1:0] addrReg;
    logic [ADDR_W:0]   wordCountReg;
    logic [ADDR_W:0]   wordCountInc;
    logic              romWeReg;
    logic [ADDR_W-1:0] romAddrReg;
    logic [DATA_W-1:0] romWdataReg;
    logic              cpuHoldReg;

    logic              acceptWord;
    logic              lenBad;
    logic              lastWord;

    // Stream is accepted only while a frame is in progress.
    assign s_ready      = (stateReg == LEN) || (stateReg == LOAD) || (stateReg == CHECK);
    assign busy         = s_ready;
    assign done         = (stateReg == DONE);
    assign err          = (stateReg == ERROR);
    assign acceptWord   = s_valid && s_ready;

    // A length of zero or one larger than the ROM cannot be loaded.
    assign lenBad       = (s_data == '0) || (32'(s_data) > ROM_DEPTH);
    assign wordCountInc = wordCountReg + (ADDR_W+1)'(1);
    assign lastWord     = (wordCountInc == lenReg);

    assign rom_we       = romWeReg;
    assign rom_addr     = romAddrReg;
    assign rom_wdata    = romWdataReg;
    assign cpu_hold     = cpuHoldReg;
    assign word_count   = wordCountReg;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg <= LEN;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic; start only restarts from a terminal state.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            LEN: begin
                if (acceptWord) begin
                    stateNext = lenBad ? ERROR : LOAD;
                end
            end
            LOAD: begin
                if (acceptWord && lastWord) begin
                    stateNext = CHECK;
                end
            end
            CHECK: begin
                if (acceptWord) begin
                    stateNext = (s_data == sumReg) ? DONE : ERROR;
                end
            end
            DONE, ERROR: begin
                if (start) begin
                    stateNext = LEN;
                end
            end
            default: stateNext = LEN;
        endcase
    end

    // Datapath: length latch, ROM write port, running checksum, counters and CPU hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lenReg       <= '0;
            sumReg       <= '0;
            addrReg      <= '0;
            wordCountReg <= '0;
            romWeReg     <= 1'b0;
            romAddrReg   <= '0;
            romWdataReg  <= '0;
            cpuHoldReg   <= 1'b1;
        end else begin
            romWeReg <= 1'b0;
            case (stateReg)
                LEN: begin
                    if (acceptWord) begin
                        // Only in-range lengths are used, and those fit in ADDR_W+1 bits.
                        lenReg       <= s_data[ADDR_W:0];
                        sumReg       <= '0;
                        wordCountReg <= '0;
                        addrReg      <= '0;
                    end
                end
                LOAD: begin
                    if (acceptWord) begin
                        romWeReg     <= 1'b1;
                        romAddrReg   <= addrReg;
                        romWdataReg  <= s_data;
                        sumReg       <= sumReg + s_data;
                        addrReg      <= addrReg + ADDR_W'(1);
                        wordCountReg <= wordCountInc;
                    end
                end
                DONE, ERROR: begin
                    if (start) begin
                        wordCountReg <= '0;
                    end
                end
                default: ;
            endcase
            // Registered so the CPU reset changes exactly on the edge entering or leaving DONE.
            cpuHoldReg <= (stateNext != DONE);
        end
    end

endmodule

// File: doc/hack_boot_loader.md
Name: hack_boot_loader

Overview:
- Sequences program load into the HACK instruction ROM from a 16-bit word stream (host/UART-deserialiser side) over a valid/ready handshake.
- Holds the CPU in reset while loading and releases it only after a length-framed, checksum-verified image has been written.
- Sits beside the CPU/ROM32K pair in the top level and drives the ROM write port and the CPU reset.

Parameters:
- ADDR_W, 15, ROM address width; ROM depth is 2^ADDR_W words.
- DATA_W, 16, instruction/stream word width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to reload; honoured only in DONE or ERROR.
- s_valid  in  1  stream word valid.
- s_data  in  DATA_W  stream word.
- s_ready  out  1  loader can accept a word.
- rom_we  out  1  ROM write strobe.
- rom_addr  out  ADDR_W  ROM write address.
- rom_wdata  out  DATA_W  ROM write data.
- cpu_hold  out  1  active-high reset to the CPU.
- busy  out  1  high in LEN, LOAD and CHECK.
- done  out  1  high in DONE.
- err  out  1  high in ERROR.
- word_count  out  ADDR_W+1  data words written in the current load.

Behaviour:
- Transfer: a word transfers on any edge where s_valid && s_ready. s_ready = 1 in LEN, LOAD and CHECK, and 0 elsewhere. s_data is ignored when no transfer occurs.
- Reset (rst low, asynchronous):
  - state = LEN, cpu_hold = 1, s_ready = 1 (LEN).
  - rom_we = 0, rom_addr = 0, rom_wdata = 0, word_count = 0.
  - done = 0, err = 0.
  - Internal length register = 0, sum = 0.
  - Boot load therefore starts immediately after reset release.
- Frame format: a length word N, then N data words, then one checksum word. The checksum equals the sum of the N data words modulo 2^16.
- LEN: on transfer, latch N = s_data, clear sum, clear word_count and clear the address counter.
  - If N == 0 or N > 2^ADDR_W, go to ERROR.
  - Otherwise go to LOAD.
- LOAD: on each transfer:
  - Register rom_we = 1, rom_addr = address counter, rom_wdata = s_data. The write is visible one cycle after acceptance, and rom_we is high for exactly one cycle per word.
  - Add s_data to sum (wraps modulo 2^16).
  - Increment the address counter and word_count.
  - When word_count reaches N after this word, go to CHECK.
  - With no transfer, rom_we = 0.
  - The address counter never wraps, because N ≤ 2^ADDR_W. A full 32768-word image ends at address 32767.
- CHECK: on transfer, if s_data == sum go to DONE, else go to ERROR. The comparison uses the sum including the last LOAD word.
- DONE: cpu_hold = 0, done = 1, s_ready = 0. Extra stream words stall and are not consumed.
- ERROR: cpu_hold = 1, err = 1, s_ready = 0. ROM contents are left as written; there is no rollback.
- start:
  - In DONE or ERROR: go to LEN and, on the next edge, set cpu_hold = 1, clear done/err and clear word_count.
  - In LEN, LOAD or CHECK: start is ignored.
  - If start and s_valid are both high in DONE/ERROR, no transfer occurs that cycle.
- cpu_hold is high in every state except DONE. It is registered and glitch-free, and deasserts on the same edge that enters DONE.
- Reset mid-load: the partial image remains in ROM, the FSM returns to LEN, and the CPU is held.
- Latency: minimum load time for N words is N+2 accepted cycles. Final rom_we occurs one cycle after the last data word. done rises one cycle after checksum acceptance.

Decomposition:
- Shared package hack_pkg:
  - State enum {LEN, LOAD, CHECK, DONE, ERROR}.
  - HACK_ADDR_W = 15 and HACK_DATA_W = 16.
  - ROM_DEPTH = 2^HACK_ADDR_W.
- Single module, no sub-module needed. The checksum accumulator is a 16-bit register plus adder inline.
- Top-level integration: the CPU's rst is driven from cpu_hold, and ROM32K gains a write port (rom_we/rom_addr/rom_wdata).

Test Plan:
- Release rst, stream N=3, data 0x0010, 0x0020, 0x0030, checksum 0x0060 -> rom_we pulses at addresses 0, 1, 2 with matching data; done=1, cpu_hold=0, word_count=3.
- Same frame with checksum 0x0061 -> err=1, cpu_hold stays 1, s_ready=0; then pulse start and send a correct frame -> done=1.
- Length word 0x0000, and separately 0x8001 -> ERROR on the edge after acceptance; zero rom_we pulses.
- N=2 with s_valid toggled randomly, data 0xFFFF, 0x0002, checksum 0x0001 (wrap) -> exactly 2 writes, done=1; no transfer is counted while s_valid=0.
- Assert rst low mid-LOAD after 5 of 10 words -> all outputs at reset values immediately (asynchronous), state LEN; a new full frame then loads correctly from address 0.
- Pulse start during LOAD, and hold s_valid=1 in DONE -> start is ignored, the load completes, and s_ready=0 with no further rom_we in DONE.
